vga_console_ctrl: RTL and testbench
===================================

Name: vga_console_ctrl

Overview:
Command-driven text console sequencer that owns the CPU-side port of the 80x30 VGA text frame buffer.
- Accepts simple commands (put char, set attribute, set cursor, clear, newline) over a valid/ready handshake.
- Tracks the cursor, translates (row, col) into frame-buffer word address and byte enables, and runs multi-cycle clear and scroll sequences autonomously.
- Sits between the CPU/MMIO decoder and the frame buffer's write/read port (1-cycle registered read latency).

Parameters:
COLS, 80, text columns; must be even (2 cells per 32-bit word)
ROWS, 30, text rows
ADDR_W, 11, frame buffer word address width
BLANK_CHAR, 8'h20, character code used for clear/scroll fill
CLEAR_ON_RESET, 1, when 1 the controller runs a full CLEAR after reset

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command this cycle
cmd_op  in  3  0 NOP, 1 PUTC, 2 SET_ATTR, 3 SET_CURSOR, 4 CLEAR, 5 NEWLINE; 6-7 treated as NOP
cmd_data  in  16  PUTC: [7:0] char; SET_ATTR: [3:0] fg, [7:4] bg; SET_CURSOR: [6:0] col, [12:8] row
busy  out  1  clear/scroll sequence in progress
cursor_col  out  7  current column
cursor_row  out  5  current row
fb_en  out  1  frame buffer port enable
fb_we  out  4  byte write enables
fb_addr  out  ADDR_W  word address
fb_wdata  out  32  write data
fb_rdata  in  32  read data, valid the cycle after fb_en with fb_we==0

Behaviour:
- Cell format: 16 bits = {bg[3:0], fg[3:0], char[7:0]}. Even column is in word bits [15:0]; odd column is in [31:16].
- Word address = row*(COLS/2) + (col>>1).
- PUTC write: fb_we = 4'b0011 (even col) or 4'b1100 (odd col); cell is replicated in both halves of fb_wdata.
- Handshake: transfer occurs when cmd_valid & cmd_ready. cmd_ready = 1 only in IDLE.
- States: IDLE, EXEC, CLR, SCR_RD, SCR_WR, SCR_FILL.
- EXEC is one cycle. Command effects are issued at accept+1; cmd_ready returns at accept+2 unless a sequence starts.
- PUTC, printable char: write the cell at the cursor with the current attr, then col+1.
  - col==COLS-1: col=0, row+1.
  - row==ROWS-1 at wrap: row stays ROWS-1 and the controller enters SCR_RD.
- PUTC 0x0A or NEWLINE: col=0; row+1 or scroll as above. No write.
- PUTC 0x0D: col=0. No write.
- SET_ATTR: latch attr. Reset value is 8'h07.
- SET_CURSOR: col is clamped to COLS-1 and row is clamped to ROWS-1.
- CLEAR: writes blank cells with the current attr to all ROWS*COLS/2 words.
  - Address runs 0 ascending, one word per cycle, fb_we=4'hF.
  - Cursor is set to (0,0) at completion.
  - Duration is 1200 cycles at defaults.
- Scroll, for dst = 0 .. (ROWS-1)*COLS/2 - 1:
  - SCR_RD: read address dst+COLS/2.
  - SCR_WR: write fb_rdata to dst with fb_we=4'hF.
  - Rate is 2 cycles per word.
- SCR_FILL: writes blank words to the last row (COLS/2 cycles), then returns to IDLE.
- Total scroll duration is 2*1160 + 40 = 2360 cycles at defaults.
- busy=1 in CLR, SCR_RD, SCR_WR and SCR_FILL.
- cmd_ready=0 during any sequence; commands are held off, never dropped.
- Outside write/read cycles, fb_en=0 and fb_we=0. fb_addr and fb_wdata are don't-care when fb_en=0.
- Reset (any time, including mid-sequence) aborts immediately: partially written words are left as-is.
  - Reset values: cursor (0,0); attr 07; fb_en=0; fb_we=0; busy=0.
  - CLEAR_ON_RESET=1: enters CLR on the first cycle after rst deasserts (cmd_ready=0, busy=1).
  - CLEAR_ON_RESET=0: enters IDLE (cmd_ready=1).
- Address arithmetic uses ADDR_W-bit unsigned values. The maximum address 1199 fits; no wrap occurs within legal parameters.

Decomposition:
- Package vga_console_pkg holds:
  - cmd_op encodings
  - state enum
  - cell field offsets
  - WORDS_PER_ROW = COLS/2 and FB_WORDS = ROWS*COLS/2
  - blank-cell constructor function
- Optional sub-module vga_console_addr: combinational (row, col) to word address and byte enables. All sequencing stays in the top module.

Test Plan:
1. Reset with CLEAR_ON_RESET=1 -> 1200 consecutive writes, addr 0..1199, wdata 32'h07200720, fb_we=F; then cmd_ready=1, cursor (0,0).
2. SET_ATTR 0x1E, then PUTC 'A' at (0,0) and PUTC 'B' -> writes:
   - addr 0, fb_we=0011, wdata 32'h1E411E41
   - addr 0, fb_we=1100, wdata 32'h1E421E42
   - cursor (2,0).
3. SET_CURSOR col=79 row=5, then PUTC 'x' -> write to addr 239, fb_we=1100; cursor (0,6).
4. SET_CURSOR col=200 row=31 -> cursor clamps to (79,29).
5. At row 29, NEWLINE with a model frame buffer -> busy high for 2360 cycles; word k ends equal to old word k+40 for k<1160; words 1160..1199 are blank; cursor (0,29).
6. Assert rst during scroll cycle 500 with CLEAR_ON_RESET=0 -> next cycle fb_en=0, busy=0, cmd_ready=1, cursor (0,0).

Source files
------------

// File: rtl/vga_console_pkg.sv
// Shared definitions for the VGA text console sequencer: command and state
// encodings, cell layout, default geometry and the cell constructor.
package vga_console_pkg;

    localparam int unsigned DEF_COLS      = 80;
    localparam int unsigned DEF_ROWS      = 30;
    localparam int unsigned WORDS_PER_ROW = DEF_COLS / 2;
    localparam int unsigned FB_WORDS      = DEF_ROWS * DEF_COLS / 2;

    // Cell layout: {bg[3:0], fg[3:0], char[7:0]}
    localparam int unsigned CELL_CHAR_LSB = 0;
    localparam int unsigned CELL_FG_LSB   = 8;
    localparam int unsigned CELL_BG_LSB   = 12;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_PUTC       = 3'd1,
        OP_SET_ATTR   = 3'd2,
        OP_SET_CURSOR = 3'd3,
        OP_CLEAR      = 3'd4,
        OP_NEWLINE    = 3'd5,
        OP_RSVD6      = 3'd6,
        OP_RSVD7      = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        CLR,
        SCR_RD,
        SCR_WR,
        SCR_FILL
    } state_e;

    // Attribute byte is {bg, fg}; builds one 16-bit cell.
    function automatic logic [15:0] make_cell(input logic [7:0] attr, input logic [7:0] ch);
        logic [15:0] c;
        c = '0;
        c[CELL_CHAR_LSB +: 8] = ch;
        c[CELL_FG_LSB +: 4]   = attr[3:0];
        c[CELL_BG_LSB +: 4]   = attr[7:4];
        return c;
    endfunction

endpackage

// File: rtl/vga_console_if.sv
// Command handshake bundle between the MMIO decoder and the console sequencer.
interface vga_console_if;
    logic        valid;
    logic        ready;
    logic [2:0]  op;
    logic [15:0] data;

    modport master (output valid, output op, output data, input ready);
    modport slave  (input valid, input op, input data, output ready);
endinterface

// File: rtl/vga_console_addr.sv
// Maps a (row, col) cursor position to the frame-buffer word address and
// the byte enables selecting that cell's half of the word.
module vga_console_addr #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ADDR_W = 11
) (
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        we
);
    localparam logic [ADDR_W-1:0] WPR = ADDR_W'(COLS / 2);

    // Two cells per word: even column low half, odd column high half.
    always_comb begin
        addr = ADDR_W'(row) * WPR + ADDR_W'(col[6:1]);
        we   = col[0] ? 4'b1100 : 4'b0011;
    end
endmodule

// File: rtl/vga_console_ctrl.sv
// Text console sequencer owning the CPU-side frame-buffer port: executes
// console commands, tracks the cursor and runs clear/scroll sequences.
module vga_console_ctrl
    import vga_console_pkg::*;
#(
    parameter int unsigned COLS           = DEF_COLS,
    parameter int unsigned ROWS           = DEF_ROWS,
    parameter int unsigned ADDR_W         = 11,
    parameter logic [7:0]  BLANK_CHAR     = 8'h20,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    vga_console_if.slave      cmd,
    output logic              busy,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              fb_en,
    output logic [3:0]        fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       fb_wdata,
    input  logic [31:0]       fb_rdata
);
    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] WPR_A    = ADDR_W'(COLS / 2);
    localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(ROWS * COLS / 2 - 1);
    localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'((ROWS - 1) * COLS / 2 - 1);

    state_e            state;
    op_e               op;
    logic              ready_q;
    logic [7:0]        attr;
    logic              clr_pend;
    logic              scr_pend;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_inc;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] cell_addr;
    logic [3:0]        cell_we;
    logic [4:0]        next_row;
    logic              at_last_row;
    logic [15:0]       put_cell;
    logic [31:0]       blank_word;
    logic              data_unused;

    vga_console_addr #(.COLS(COLS), .ADDR_W(ADDR_W)) u_addr (
        .row  (cursor_row),
        .col  (cursor_col),
        .addr (cell_addr),
        .we   (cell_we)
    );

    assign op          = op_e'(cmd.op);
    assign cmd.ready   = ready_q;
    assign idx_inc     = idx + ADDR_W'(1);
    assign at_last_row = (cursor_row == LAST_ROW);
    assign next_row    = at_last_row ? cursor_row : cursor_row + 5'd1;
    assign put_cell    = make_cell(attr, cmd.data[7:0]);
    assign blank_word  = {2{make_cell(attr, BLANK_CHAR)}};
    assign data_unused = ^cmd.data[15:13];

    // Scroll copy passes read data straight through in SCR_WR so a word moves
    // every two cycles on the single-port frame buffer.
    assign fb_wdata = (state == SCR_WR) ? fb_rdata : wdata_q;

    // Command execution, cursor tracking and clear/scroll sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? EXEC : IDLE;
            ready_q    <= !CLEAR_ON_RESET;
            clr_pend   <= CLEAR_ON_RESET;
            scr_pend   <= 1'b0;
            busy       <= 1'b0;
            cursor_col <= '0;
            cursor_row <= '0;
            attr       <= 8'h07;
            fb_en      <= 1'b0;
            fb_we      <= '0;
            fb_addr    <= '0;
            wdata_q    <= '0;
            idx        <= '0;
        end else begin
            fb_en <= 1'b0;
            fb_we <= '0;
            case (state)
                IDLE: begin
                    if (cmd.valid && ready_q) begin
                        ready_q <= 1'b0;
                        state   <= EXEC;
                        case (op)
                            OP_PUTC: begin
                                if (cmd.data[7:0] == CHAR_LF) begin
                                    cursor_col <= '0;
                                    cursor_row <= next_row;
                                    scr_pend   <= at_last_row;
                                end else if (cmd.data[7:0] == CHAR_CR) begin
                                    cursor_col <= '0;
                                end else begin
                                    fb_en   <= 1'b1;
                                    fb_we   <= cell_we;
                                    fb_addr <= cell_addr;
                                    wdata_q <= {2{put_cell}};
                                    if (cursor_col == LAST_COL) begin
                                        cursor_col <= '0;
                                        cursor_row <= next_row;
                                        scr_pend   <= at_last_row;
                                    end else begin
                                        cursor_col <= cursor_col + 7'd1;
                                    end
                                end
                            end
                            OP_SET_ATTR: attr <= cmd.data[7:0];
                            OP_SET_CURSOR: begin
                                cursor_col <= (cmd.data[6:0] > LAST_COL) ? LAST_COL : cmd.data[6:0];
                                cursor_row <= (cmd.data[12:8] > LAST_ROW) ? LAST_ROW : cmd.data[12:8];
                            end
                            OP_CLEAR: clr_pend <= 1'b1;
                            OP_NEWLINE: begin
                                cursor_col <= '0;
                                cursor_row <= next_row;
                                scr_pend   <= at_last_row;
                            end
                            default: ;
                        endcase
                    end
                end
                EXEC: begin
                    clr_pend <= 1'b0;
                    scr_pend <= 1'b0;
                    idx      <= '0;
                    if (clr_pend) begin
                        state   <= CLR;
                        busy    <= 1'b1;
                        fb_en   <= 1'b1;
                        fb_we   <= '1;
                        fb_addr <= '0;
                        wdata_q <= blank_word;
                    end else if (scr_pend) begin
                        state   <= SCR_RD;
                        busy    <= 1'b1;
                        fb_en   <= 1'b1;
                        fb_addr <= WPR_A;
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                CLR: begin
                    if (idx == FB_LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        ready_q    <= 1'b1;
                        cursor_col <= '0;
                        cursor_row <= '0;
                    end else begin
                        idx     <= idx_inc;
                        fb_en   <= 1'b1;
                        fb_we   <= '1;
                        fb_addr <= idx_inc;
                    end
                end
                SCR_RD: begin
                    state   <= SCR_WR;
                    fb_en   <= 1'b1;
                    fb_we   <= '1;
                    fb_addr <= idx;
                end
                SCR_WR: begin
                    idx   <= idx_inc;
                    fb_en <= 1'b1;
                    if (idx == SCR_LAST) begin
                        state   <= SCR_FILL;
                        fb_we   <= '1;
                        fb_addr <= idx_inc;
                        wdata_q <= blank_word;
                    end else begin
                        state   <= SCR_RD;
                        fb_addr <= idx_inc + WPR_A;
                    end
                end
                SCR_FILL: begin
                    if (idx == FB_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        idx     <= idx_inc;
                        fb_en   <= 1'b1;
                        fb_we   <= '1;
                        fb_addr <= idx_inc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_console_ctrl.sv
// Scoreboard bench for vga_console_ctrl: expected frame-buffer writes are
// queued by the stimulus and checked by an independent write monitor.
module tb_vga_console_ctrl;
    import vga_console_pkg::*;

    localparam int FBW = 1200;

    typedef struct packed {
        logic [10:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        fb_en;
    logic [3:0]  fb_we;
    logic [10:0] fb_addr;
    logic [31:0] fb_wdata;
    logic [31:0] fb_rdata = '0;

    logic        rst0 = 1'b1;
    logic        busy0;
    logic [6:0]  col0;
    logic [4:0]  row0;
    logic        en0;
    logic [3:0]  we0;
    logic [10:0] addr0;
    logic [31:0] wdata0;
    logic [31:0] rdata0 = '0;

    logic [31:0] mem [0:FBW-1];
    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;

    vga_console_if cif ();
    vga_console_if cif0 ();

    vga_console_ctrl u_dut (
        .clk(clk), .rst(rst), .cmd(cif), .busy(busy),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
    );

    vga_console_ctrl #(.CLEAR_ON_RESET(1'b0)) u_dut0 (
        .clk(clk), .rst(rst0), .cmd(cif0), .busy(busy0),
        .cursor_col(col0), .cursor_row(row0),
        .fb_en(en0), .fb_we(we0), .fb_addr(addr0),
        .fb_wdata(wdata0), .fb_rdata(rdata0)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Frame buffer model with 1-cycle registered read.
    always @(posedge clk) begin
        if (fb_en) begin
            if (fb_we == 4'h0) fb_rdata <= mem[fb_addr];
            else for (int b = 0; b < 4; b++)
                if (fb_we[b]) mem[fb_addr][8*b +: 8] = fb_wdata[8*b +: 8];
        end
    end

    // Write monitor: every DUT write must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && fb_en && fb_we != 4'h0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%0d we=%h data=%h, none expected", fb_addr, fb_we, fb_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (fb_addr !== e.addr || fb_we !== e.we || fb_wdata !== e.data) begin
                    bad++;
                    $display("FAIL write: got addr=%0d we=%h data=%h, want addr=%0d we=%h data=%h",
                             fb_addr, fb_we, fb_wdata, e.addr, e.we, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int addr, input logic [3:0] we, input logic [31:0] data);
        exp_q.push_back('{addr: 11'(addr), we: we, data: data});
    endtask

    task automatic send(input bit to0, input logic [2:0] op, input logic [15:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!(to0 ? cif0.ready : cif.ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!(to0 ? cif0.ready : cif.ready)) begin
            total++;
            bad++;
            $display("FAIL send_ready: ready stayed 0 for %0d cycles, want 1", n);
        end
        if (to0) begin
            cif0.valid = 1'b1; cif0.op = op; cif0.data = data;
        end else begin
            cif.valid = 1'b1; cif.op = op; cif.data = data;
        end
        @(posedge clk);
        #1;
        cif.valid  = 1'b0;
        cif0.valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cycles);
        int n;
        n = 0;
        busy_cycles = 0;
        while (n < 5000) begin
            @(negedge clk);
            if (cif.ready) break;
            if (busy) busy_cycles++;
            n++;
        end
        if (!cif.ready) begin
            total++;
            bad++;
            $display("FAIL wait_idle: ready stayed 0 for %0d cycles, want 1", n);
        end
    endtask

    task automatic chk_cursor(input string name, input int col, input int row);
        chk({name, "_col"}, 32'(cursor_col), 32'(col));
        chk({name, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    initial begin
        int bc;
        int errs;
        cif.valid = 1'b0;  cif.op = '0;  cif.data = '0;
        cif0.valid = 1'b0; cif0.op = '0; cif0.data = '0;
        for (int k = 0; k < FBW; k++) mem[k] = '0;

        // 1: reset, then automatic clear with default attribute 07
        for (int k = 0; k < FBW; k++) push(k, 4'hF, 32'h07200720);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fb_en", 32'(fb_en), 32'd0);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_ready", 32'(cif.ready), 32'd0);
        chk_cursor("rst", 0, 0);
        rst = 1'b0;
        wait_idle(bc);
        chk("clr_busy_cycles", 32'(bc), 32'd1200);
        chk("clr_ready", 32'(cif.ready), 32'd1);
        chk_cursor("clr_done", 0, 0);

        // 2: attribute and two characters sharing word 0
        send(0, OP_SET_ATTR, 16'h001E);
        push(0, 4'b0011, 32'h1E411E41);
        send(0, OP_PUTC, 16'h0041);
        push(0, 4'b1100, 32'h1E421E42);
        send(0, OP_PUTC, 16'h0042);
        wait_idle(bc);
        chk_cursor("putc_ab", 2, 0);

        // 3: end-of-line wrap, then CR, LF and a reserved opcode
        send(0, OP_SET_CURSOR, 16'h054F);
        push(239, 4'b1100, 32'h1E781E78);
        send(0, OP_PUTC, 16'h0078);
        wait_idle(bc);
        chk_cursor("wrap", 0, 6);
        push(240, 4'b0011, 32'h1E791E79);
        send(0, OP_PUTC, 16'h0079);
        wait_idle(bc);
        chk_cursor("putc_y", 1, 6);
        send(0, OP_PUTC, 16'h000D);
        wait_idle(bc);
        chk_cursor("cr", 0, 6);
        send(0, OP_PUTC, 16'h000A);
        wait_idle(bc);
        chk_cursor("lf", 0, 7);
        send(0, 3'd7, 16'h1234);
        wait_idle(bc);
        chk_cursor("nop7", 0, 7);

        // 4: cursor clamping
        send(0, OP_SET_CURSOR, 16'h1F50);
        wait_idle(bc);
        chk_cursor("clamp_80_31", 79, 29);
        send(0, OP_SET_CURSOR, 16'h1E7F);
        wait_idle(bc);
        chk_cursor("clamp_127_30", 79, 29);

        // 5: scroll from the last row over a patterned frame buffer
        send(0, OP_SET_ATTR, 16'h0007);
        send(0, OP_SET_CURSOR, 16'h1D05);
        wait_idle(bc);
        for (int k = 0; k < FBW; k++) mem[k] = 32'hA5000000 | 32'(k);
        for (int d = 0; d < 1160; d++) push(d, 4'hF, 32'hA5000000 | 32'(d + 40));
        for (int d = 1160; d < FBW; d++) push(d, 4'hF, 32'h07200720);
        send(0, OP_NEWLINE, 16'h0000);
        wait_idle(bc);
        chk("scroll_busy_cycles", 32'(bc), 32'd2360);
        chk_cursor("scroll", 0, 29);
        errs = 0;
        for (int k = 0; k < FBW; k++)
            if (mem[k] !== ((k < 1160) ? (32'hA5000000 | 32'(k + 40)) : 32'h07200720)) errs++;
        chk("scroll_image_errors", 32'(errs), 32'd0);

        // CLEAR command with a new attribute homes the cursor
        send(0, OP_SET_ATTR, 16'h005A);
        for (int k = 0; k < FBW; k++) push(k, 4'hF, 32'h5A205A20);
        send(0, OP_CLEAR, 16'h0000);
        wait_idle(bc);
        chk("clear_busy_cycles", 32'(bc), 32'd1200);
        chk_cursor("clear", 0, 0);

        // 6: reset mid-scroll on the instance without clear-on-reset
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        chk("r0_ready_after_rst", 32'(cif0.ready), 32'd1);
        chk("r0_busy_after_rst", 32'(busy0), 32'd0);
        send(1, OP_SET_CURSOR, 16'h1D00);
        send(1, OP_NEWLINE, 16'h0000);
        bc = 0;
        while (!busy0 && bc < 10) begin
            @(negedge clk);
            bc++;
        end
        chk("r0_scroll_started", 32'(busy0), 32'd1);
        repeat (499) @(negedge clk);
        chk("r0_midscroll_busy", 32'(busy0), 32'd1);
        chk("r0_midscroll_en", 32'(en0), 32'd1);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("r0_abort_fb_en", 32'(en0), 32'd0);
        chk("r0_abort_fb_we", 32'(we0), 32'd0);
        chk("r0_abort_busy", 32'(busy0), 32'd0);
        chk("r0_abort_ready", 32'(cif0.ready), 32'd1);
        chk("r0_abort_col", 32'(col0), 32'd0);
        chk("r0_abort_row", 32'(row0), 32'd0);
        rst0 = 1'b0;

        repeat (2) @(negedge clk);
        chk("sb_pending", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
